// File: rtl/apb_slave_regs_pkg.sv
// Shared types and constants for the APB register slave: FSM state encoding,
// data width, register-index field position and wait-state limits.
package apb_pkg;

    localparam int APB_DATA_W      = 32;
    localparam int IDX_LSB         = 2;
    localparam int IDX_MSB         = 5;
    localparam int IDX_W           = IDX_MSB - IDX_LSB + 1;
    localparam int MAX_WAIT_CYCLES = 7;
    localparam int WAIT_CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Register index carried in the word-address bits of a byte address.
    function automatic logic [IDX_W-1:0] get_reg_index(input logic [IDX_MSB:0] addr);
        return addr[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between the bridge (master) and the register slave.
interface apb_slave_regs_if;
    import apb_pkg::*;

    logic                  psel_en;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_DATA_W-1:0] PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output psel_en, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  psel_en, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regs_wait_counter.sv
// Wait-state down-counter: loaded at setup, decremented while waiting,
// done flags the last wait cycle.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  done
);

    logic [WAIT_CNT_W-1:0] cnt_r;

    // Counter register; saturates at zero so a stray decrement never wraps.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_r <= WAIT_CNT_W'(0);
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != WAIT_CNT_W'(0))) begin
            cnt_r <= cnt_r - WAIT_CNT_W'(1);
        end
    end

    assign done = (cnt_r == WAIT_CNT_W'(1));

endmodule

// File: rtl/apb_slave_regs.sv
// APB register slave: IDLE/WAIT/ACCESS handshake FSM, address decode,
// register array with read-only slots sourced from hw_in, and write strobes.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] RO_MASK     = 16'h0001
) (
    input  logic                           clk,
    input  logic                           n_rst,
    apb_slave_regs_if.slave                apb,
    input  logic [NUM_REGS*APB_DATA_W-1:0] hw_in,
    output logic [NUM_REGS*APB_DATA_W-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_strobe
);

    localparam logic [IDX_W:0]          NUM_REGS_W = (IDX_W+1)'(NUM_REGS);
    localparam logic [WAIT_CNT_W-1:0]   WAIT_LOAD  = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic                    NO_WAIT    = (WAIT_CYCLES == 0);

    apb_state_e              state_r;
    apb_state_e              state_nxt_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    err_s;
    logic                    setup_s;
    logic                    commit_s;
    logic                    cnt_done_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    write_r;
    logic                    err_r;
    logic [APB_DATA_W-1:0]   wdata_r;
    logic [APB_DATA_W-1:0]   regs_r [NUM_REGS];
    logic [APB_DATA_W-1:0]   hw_arr_s [NUM_REGS];
    logic [APB_DATA_W-1:0]   rd_data_s;
    logic [NUM_REGS-1:0]     wr_strobe_r;
    logic                    pready_s;
    logic                    pslverr_s;
    logic [APB_DATA_W-1:0]   prdata_s;
    logic                    unused_addr_s;

    assign unused_addr_s = ^apb.PADDR[APB_DATA_W-1:IDX_MSB+1];

    assign idx_s    = get_reg_index(apb.PADDR[IDX_MSB:0]);
    assign err_s    = (apb.PADDR[1:0] != 2'b00)
                   || ({1'b0, idx_s} >= NUM_REGS_W)
                   || (apb.PWRITE && RO_MASK[idx_s]);
    assign setup_s  = (state_r == ST_IDLE) && apb.psel_en && !apb.PENABLE;
    assign commit_s = (state_r == ST_ACCESS) && apb.psel_en && apb.PENABLE
                   && !err_r && write_r;

    apb_wait_counter u_wait_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (setup_s),
        .load_val (WAIT_LOAD),
        .dec      (state_r == ST_WAIT),
        .done     (cnt_done_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a dropped select aborts straight back to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (setup_s) begin
                    state_nxt_s = NO_WAIT ? ST_ACCESS : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!apb.psel_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_done_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Setup-phase capture: later PWDATA/PADDR changes cannot affect the transfer.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            idx_r   <= {IDX_W{1'b0}};
            write_r <= 1'b0;
            err_r   <= 1'b0;
            wdata_r <= 32'h0;
        end else if (setup_s) begin
            idx_r   <= idx_s;
            write_r <= apb.PWRITE;
            err_r   <= err_s;
            wdata_r <= apb.PWDATA;
        end
    end

    // Register array and write strobes; RO slots are never written.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'h0;
            end
            wr_strobe_r <= {NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && (idx_r == IDX_W'(i))) begin
                    regs_r[i] <= wdata_r;
                end
                wr_strobe_r[i] <= commit_s && (idx_r == IDX_W'(i));
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
        assign hw_arr_s[g]                        = hw_in[g*APB_DATA_W +: APB_DATA_W];
        assign regs_out[g*APB_DATA_W +: APB_DATA_W] = regs_r[g];
    end

    // Read mux: read-only registers return the live hardware value.
    always_comb begin
        rd_data_s = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (idx_r == IDX_W'(i)) ? (RO_MASK[i] ? hw_arr_s[i] : regs_r[i])
                                             : rd_data_s;
        end
    end

    // FSM outputs; everything is held at zero while reset is asserted.
    always_comb begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = 32'h0;
        if (n_rst && (state_r == ST_ACCESS)) begin
            pready_s  = 1'b1;
            pslverr_s = err_r;
            if (!err_r && !write_r) begin
                prdata_s = rd_data_s;
            end else begin
                prdata_s = 32'h0;
            end
        end else begin
            pready_s  = 1'b0;
            pslverr_s = 1'b0;
            prdata_s  = 32'h0;
        end
    end

    assign apb.PREADY  = pready_s;
    assign apb.PSLVERR = pslverr_s;
    assign apb.PRDATA  = prdata_s;
    assign wr_strobe   = wr_strobe_r;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench: a zero-wait and a three-wait instance of apb_slave_regs,
// checking handshake timing, errors, RO reads, aborts and reset.
module tb_apb_slave_regs;

    logic         clk;
    logic         n_rst;
    logic [255:0] hw_in;
    logic [255:0] regs0, regs3;
    logic [7:0]   strb0, strb3;
    logic [255:0] exp_regs;
    int           total;
    int           passed;
    int           waits;
    logic         err;
    logic [31:0]  rd;

    apb_slave_regs_if i0 ();
    apb_slave_regs_if i3 ();

    apb_slave_regs #(.NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(16'h0001)) dut0 (
        .clk(clk), .n_rst(n_rst), .apb(i0), .hw_in(hw_in), .regs_out(regs0), .wr_strobe(strb0)
    );

    apb_slave_regs #(.NUM_REGS(8), .WAIT_CYCLES(3), .RO_MASK(16'h0001)) dut3 (
        .clk(clk), .n_rst(n_rst), .apb(i3), .hw_in(hw_in), .regs_out(regs3), .wr_strobe(strb3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input int d, input logic sel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            i0.psel_en = sel; i0.PENABLE = en; i0.PWRITE = wr; i0.PADDR = a; i0.PWDATA = w;
        end else begin
            i3.psel_en = sel; i3.PENABLE = en; i3.PWRITE = wr; i3.PADDR = a; i3.PWDATA = w;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? i0.PREADY : i3.PREADY;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? i0.PSLVERR : i3.PSLVERR;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? i0.PRDATA : i3.PRDATA;
    endfunction

    // Full transfer: setup, access phase (PWDATA switched to w_late), bounded wait for PREADY.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] w_late, output int nwait, output logic e,
                        output logic [31:0] r);
        drive(d, 1'b1, 1'b0, wr, a, w);
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, wr, a, w_late);
        nwait = 0;
        while (get_ready(d) !== 1'b1 && nwait < 20) begin
            @(posedge clk); #1;
            nwait++;
        end
        e = get_err(d);
        r = get_rdata(d);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        hw_in  = 256'h0;
        for (int i = 1; i < 8; i++) hw_in[i*32 +: 32] = 32'h11110000 + 32'(i);
        hw_in[31:0] = 32'hA5A5A5A5;
        exp_regs = 256'h0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready",  {255'h0, i3.PREADY}, 256'h0);
        chk("rst_pslverr", {255'h0, i3.PSLVERR}, 256'h0);
        chk("rst_prdata",  {224'h0, i3.PRDATA}, 256'h0);
        chk("rst_regs3",   regs3, 256'h0);
        chk("rst_strobe3", {248'h0, strb3}, 256'h0);
        chk("rst_regs0",   regs0, 256'h0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write to reg2.
        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 32'hDEADBEEF, waits, err, rd);
        chk("w0_waits",  256'(waits), 256'd0);
        chk("w0_err",    {255'h0, err}, 256'h0);
        chk("w0_reg2",   {224'h0, regs0[95:64]}, {224'h0, 32'hDEADBEEF});
        chk("w0_strobe", {248'h0, strb0}, {248'h0, 8'b0000_0100});
        @(posedge clk); #1;
        chk("w0_strobe_off", {248'h0, strb0}, 256'h0);

        // Three-wait write then read of reg2.
        xfer(3, 1'b1, 32'h8, 32'hDEADBEEF, 32'hDEADBEEF, waits, err, rd);
        exp_regs[95:64] = 32'hDEADBEEF;
        chk("w3_waits",  256'(waits), 256'd3);
        chk("w3_err",    {255'h0, err}, 256'h0);
        chk("w3_strobe", {248'h0, strb3}, {248'h0, 8'b0000_0100});
        chk("w3_regs",   regs3, exp_regs);
        @(posedge clk); #1;
        xfer(3, 1'b0, 32'h8, 32'h0, 32'h0, waits, err, rd);
        chk("r3_waits", 256'(waits), 256'd3);
        chk("r3_err",   {255'h0, err}, 256'h0);
        chk("r3_data",  {224'h0, rd}, {224'h0, 32'hDEADBEEF});

        // Write to read-only reg0, then read it back from hw_in.
        xfer(3, 1'b1, 32'h0, 32'h1234, 32'h1234, waits, err, rd);
        chk("ro_w_err",    {255'h0, err}, 256'h1);
        chk("ro_w_strobe", {248'h0, strb3}, 256'h0);
        chk("ro_w_regs",   regs3, exp_regs);
        xfer(3, 1'b0, 32'h0, 32'h0, 32'h0, waits, err, rd);
        chk("ro_r_err",  {255'h0, err}, 256'h0);
        chk("ro_r_data", {224'h0, rd}, {224'h0, 32'hA5A5A5A5});

        // Out-of-range read and misaligned write.
        xfer(3, 1'b0, 32'h20, 32'h0, 32'h0, waits, err, rd);
        chk("oor_err",  {255'h0, err}, 256'h1);
        chk("oor_data", {224'h0, rd}, 256'h0);
        xfer(3, 1'b1, 32'h6, 32'hFFFF0000, 32'hFFFF0000, waits, err, rd);
        chk("mis_err",    {255'h0, err}, 256'h1);
        chk("mis_data",   {224'h0, rd}, 256'h0);
        chk("mis_strobe", {248'h0, strb3}, 256'h0);
        chk("mis_regs",   regs3, exp_regs);

        // PWDATA changed after setup must not be written.
        xfer(3, 1'b1, 32'h4, 32'h00000055, 32'hFFFFFFFF, waits, err, rd);
        exp_regs[63:32] = 32'h00000055;
        chk("late_err",    {255'h0, err}, 256'h0);
        chk("late_strobe", {248'h0, strb3}, {248'h0, 8'b0000_0010});
        chk("late_regs",   regs3, exp_regs);
        @(posedge clk); #1;

        // PENABLE without setup in IDLE is ignored.
        drive(3, 1'b1, 1'b1, 1'b1, 32'h10, 32'h44);
        repeat (5) @(posedge clk);
        #1;
        chk("noset_ready",  {255'h0, i3.PREADY}, 256'h0);
        chk("noset_strobe", {248'h0, strb3}, 256'h0);
        chk("noset_regs",   regs3, exp_regs);
        drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;

        // Master abort in the second wait cycle of a write to reg3.
        drive(3, 1'b1, 1'b0, 1'b1, 32'hC, 32'h33333333);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 32'hC, 32'h33333333);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 1'b1, 32'hC, 32'h33333333);
        @(posedge clk); #1;
        chk("abort_ready1", {255'h0, i3.PREADY}, 256'h0);
        @(posedge clk); #1;
        chk("abort_ready2", {255'h0, i3.PREADY}, 256'h0);
        chk("abort_strobe", {248'h0, strb3}, 256'h0);
        chk("abort_regs",   regs3, exp_regs);
        @(posedge clk); #1;
        chk("abort_strobe2", {248'h0, strb3}, 256'h0);

        // Reset asserted mid-WAIT.
        drive(3, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0BAD0BAD);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0BAD0BAD);
        n_rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_regs",   regs3, 256'h0);
        chk("mrst_ready",  {255'h0, i3.PREADY}, 256'h0);
        chk("mrst_strobe", {248'h0, strb3}, 256'h0);
        n_rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mrst_after_regs",  regs3, 256'h0);
        chk("mrst_after_ready", {255'h0, i3.PREADY}, 256'h0);
        drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of 32-bit registers (2..16).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: wait states inserted before PREADY (0..7).
REQ-003 SHALL have parameter RO_MASK, default 16'h0001: register i is read-only when bit i is set.
REQ-004 SHALL have `clk`  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have `n_rst`  in  1  reset, synchronous and active-low.
REQ-006 SHALL have `psel_en`  in  1  APB select from the bridge.
REQ-007 SHALL have `PENABLE`  in  1  APB access-phase indicator.
REQ-008 SHALL have `PWRITE`  in  1  1 = write, 0 = read.
REQ-009 SHALL have `PADDR`  in  32  byte address; bits [5:2] form the register index.
REQ-010 SHALL have `PWDATA`  in  32  write data.
REQ-011 SHALL have `PRDATA`  out  32  read data.
REQ-012 SHALL have `PREADY`  out  1  transfer completes in this cycle.
REQ-013 SHALL have `PSLVERR`  out  1  transfer error; valid only when PREADY=1.
REQ-014 SHALL have `hw_in`  in  NUM_REGS*32  values returned for read-only registers.
REQ-015 SHALL have `regs_out`  out  NUM_REGS*32  current contents of the read/write registers.
REQ-016 SHALL have `wr_strobe`  out  NUM_REGS  one-cycle pulse per completed register write.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT and ACCESS.
REQ-018 In IDLE, psel_en=1 and PENABLE=0 (setup) SHALL latch index, PWRITE, PWDATA and the error flag, then go to ACCESS if WAIT_CYCLES=0, else to WAIT with the counter loaded with WAIT_CYCLES.
REQ-019 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL move to ACCESS in the cycle after the counter reaches 1; PREADY SHALL be 0 throughout WAIT.
REQ-020 PREADY SHALL be combinationally 1 only in ACCESS, so first access-phase cycle N+1 has PREADY=1 for WAIT_CYCLES=N.
REQ-021 ACCESS SHALL always return to IDLE on the next edge; no back-to-back access without a new setup.
REQ-022 The error flag SHALL be set when PADDR[1:0]!=0, or index>=NUM_REGS, or the transfer writes a RO_MASK register.
REQ-023 PSLVERR SHALL equal the latched error flag in ACCESS and SHALL be 0 in every other state.
REQ-024 A write SHALL commit on the ACCESS edge only when psel_en=1, PENABLE=1 and the error flag is clear; errored writes SHALL leave all registers unchanged.
REQ-025 wr_strobe[index] SHALL go high for exactly the cycle after the commit edge.
REQ-026 In ACCESS of an error-free read, PRDATA SHALL equal the register value (or the live hw_in slice for read-only registers); otherwise PRDATA SHALL be 32'h0.
REQ-027 If psel_en=0 while in WAIT or ACCESS (master abort), the FSM SHALL go to IDLE on the next edge with no write and no strobe.
REQ-028 A PENABLE=1 seen in IDLE without a preceding setup SHALL be ignored.
REQ-029 The latched PWDATA SHALL be the value written, so changes to PWDATA after setup SHALL have no effect.

Reset
REQ-030 n_rst=0 sampled on a clk edge SHALL force IDLE, counter=0, all registers=0, the error flag=0 and wr_strobe=0.
REQ-031 During reset, PREADY, PSLVERR and PRDATA SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no register update.

Structure
REQ-033 Package apb_pkg SHALL hold the state enum, APB_DATA_W=32, the index field position [5:2] and the localparam for the maximum WAIT_CYCLES.
REQ-034 The wait counter SHALL be the sub-module apb_wait_counter (load, decrement, done), instantiated once.
REQ-035 Decode, the register array and output muxing SHALL reside in apb_slave_regs.

Verification
REQ-036 WAIT_CYCLES=0, write PADDR=0x8 PWDATA=0xDEADBEEF -> PREADY=1 in the first access cycle, PSLVERR=0; regs_out reg2=0xDEADBEEF; wr_strobe=4'b0100 for one cycle.
REQ-037 WAIT_CYCLES=3, read PADDR=0x8 -> PREADY=0 for 3 access cycles, then PREADY=1 with PRDATA=0xDEADBEEF.
REQ-038 Write PADDR=0x0 (RO reg0) PWDATA=0x1234 -> PSLVERR=1, no wr_strobe; a later read of 0x0 returns hw_in reg0=0xA5A5A5A5.
REQ-039 Read PADDR=0x20 (index 8 >= NUM_REGS), then write PADDR=0x6 (misaligned) -> PSLVERR=1 and PRDATA=0 for both; no register changes.
REQ-040 WAIT_CYCLES=3, write to reg3 with psel_en dropped in the second wait cycle -> IDLE next edge, reg3 unchanged, no strobe; n_rst=0 mid-WAIT -> all regs_out=0 next edge.
